// File: rtl/serial_bit_source_pkg.sv
// Shared types and defaults for the serial bit source that feeds the 1101 detector.
package serial_bit_source_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_t;

endpackage

// File: rtl/serial_bit_source_bit_counter.sv
// Rollover bit counter: counts 0..MAX_COUNT on enable, wraps to 0, flags the last value.
module serial_bit_source_bit_counter #(
  parameter int unsigned MAX_COUNT = 7,
  parameter int unsigned CNT_W     = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic en,
  output logic at_max_c
);

  logic [CNT_W-1:0] count;

  assign at_max_c = (count == CNT_W'(MAX_COUNT));

  // Clear wins over enable; enable at the last value rolls over to zero
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= at_max_c ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source with a one-word holding register for gapless streaming
// into the 1101 sequence detector.
module serial_bit_source
  import serial_bit_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_BIT   = 1'b0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic                  shift_en,
  output logic                  serial_out,
  output logic                  bit_valid,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_shifted_c;
  logic                  next_bit_c;
  logic                  last_bit_c;
  logic                  accept_c;
  logic                  load_c;
  logic                  shift_c;

  assign word_ready = !hold_full;
  assign busy       = hold_full || (state == SHIFTING);
  assign accept_c   = word_valid && !hold_full && !clear;

  generate
    if (MSB_FIRST) begin : g_msb
      assign next_bit_c      = shreg[DATA_WIDTH-1];
      assign shreg_shifted_c = {shreg[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign next_bit_c      = shreg[0];
      assign shreg_shifted_c = {1'b0, shreg[DATA_WIDTH-1:1]};
    end
  endgenerate

  serial_bit_source_bit_counter #(
    .MAX_COUNT (DATA_WIDTH - 1),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (clear || load_c),
    .en       (shift_c),
    .at_max_c (last_bit_c)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Load the shifter from hold when idle, or on the last bit so words stream back-to-back
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    shift_c   = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            load_c    = 1'b1;
            state_nxt = SHIFTING;
          end
        end
        SHIFTING: begin
          if (shift_en) begin
            shift_c = 1'b1;
            if (last_bit_c) begin
              if (hold_full) begin
                load_c = 1'b1;
              end else begin
                state_nxt = IDLE;
              end
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold       <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      serial_out <= IDLE_BIT;
      bit_valid  <= 1'b0;
    end else begin
      bit_valid <= shift_c;
      if (clear) begin
        hold_full  <= 1'b0;
        serial_out <= IDLE_BIT;
      end else begin
        if (accept_c) begin
          hold      <= word_in;
          hold_full <= 1'b1;
        end else if (load_c) begin
          hold_full <= 1'b0;
        end
        // serial_out holds its last bit while shifting is stalled
        if (shift_c) begin
          serial_out <= next_bit_c;
        end else if (state == IDLE) begin
          serial_out <= IDLE_BIT;
        end
      end
      if (load_c) begin
        shreg <= hold;
      end else if (shift_c) begin
        shreg <= shreg_shifted_c;
      end
    end
  end

endmodule
